pc_fetch_stage: RTL

Fetch stage directly upstream of the next-PC logic. It holds the 30-bit word-addressed PC register and drives it out as cur_pc. It loads the PC from next_pc, issues one instruction-memory request at a time, and captures each returned instruction into the IF/ID pipeline register. It also owns the stall buffering and the flush/redirect cleanup for the front end.

---
 rtl/pc_fetch_stage_if.sv | 29 ++
 rtl/pc_fetch_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory port of the fetch stage: one request channel (valid/ready)
// and one response channel (valid only; memory never back-pressures a response).
interface pc_fetch_stage_if #(
  parameter int PC_W = 30
);
  // Handshake: a request transfers on a clock edge where imem_req_valid and
  // imem_req_ready are both 1; imem_resp_valid is a single-cycle strobe with no ready.
  logic            imem_req_valid;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, single-outstanding instruction fetch, IF/ID register
// with a one-entry stall buffer, and redirect/flush handling for the front end.
module pc_fetch_stage #(
  parameter int              PC_W     = 30,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  next_pc,
  input  logic             pc_redirect,
  input  logic             id_stall,
  output logic [PC_W-1:0]  cur_pc,
  pc_fetch_stage_if.master imem,
  output logic             ifid_valid,
  output logic [PC_W-1:0]  ifid_pc,
  output logic [PC_W-1:0]  ifid_pc_plus1,
  output logic [31:0]      ifid_instr,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    FULL = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t          state;
  logic [PC_W-1:0] req_pc;
  logic [PC_W-1:0] buf_pc;
  logic [31:0]     buf_instr;
  logic            accept;
  logic            resp;

  assign accept = imem.imem_req_valid & imem.imem_req_ready;
  assign resp   = imem.imem_resp_valid;

  assign imem.imem_req_valid = (state == REQ);
  assign imem.imem_req_addr  = cur_pc;
  assign ifid_pc_plus1       = ifid_pc + PC_W'(1);
  assign state_dbg           = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_pc     <= RESET_PC;
      req_pc     <= '0;
      buf_pc     <= '0;
      buf_instr  <= '0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (pc_redirect) begin
      // A request accepted at the stale PC, or one still in flight, leaves a
      // response behind that DROP must swallow before the next request.
      cur_pc     <= next_pc;
      ifid_valid <= 1'b0;
      case (state)
        IDLE:    state <= IDLE;
        REQ:     state <= accept ? DROP : REQ;
        WAIT:    state <= resp ? REQ : DROP;
        FULL:    state <= REQ;
        DROP:    state <= resp ? REQ : DROP;
        default: state <= IDLE;
      endcase
    end else begin
      if (!id_stall) ifid_valid <= 1'b0;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (accept) begin
            cur_pc <= next_pc;
            req_pc <= cur_pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (resp) begin
            if (!ifid_valid || !id_stall) begin
              ifid_valid <= 1'b1;
              ifid_pc    <= req_pc;
              ifid_instr <= imem.imem_resp_data;
              state      <= REQ;
            end else begin
              buf_pc    <= req_pc;
              buf_instr <= imem.imem_resp_data;
              state     <= FULL;
            end
          end
        end
        FULL: begin
          if (!id_stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= buf_pc;
            ifid_instr <= buf_instr;
            state      <= REQ;
          end
        end
        DROP: begin
          if (resp) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
